// File: rtl/rsa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rsa_ctrl_pkg
// Shared types and defaults for the RSA processor run controller.
//   run_state_t        : controller FSM states
//   DRAIN_CYCLES_DEF   : default cycles held after end-PC detection
//   TIMEOUT_CYCLES_DEF : default RUN-state watchdog limit
//   is_busy()          : true while the core owns the data-memory port
// -----------------------------------------------------------------------------
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam int unsigned DRAIN_CYCLES_DEF   = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  function automatic logic is_busy(input run_state_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// -----------------------------------------------------------------------------
// mem_port_mux
// Combinational owner-select for the single data-memory port.
//   host_own                         : 1 = host drives the port, 0 = core does
//   host_we/host_addr/host_wdata     : host request
//   host_rdata                       : read data to host (0 when core owns)
//   cpu_mem_write/cpu_addr/cpu_wdata : core M-stage request
//   cpu_rdata                        : read data to core (0 when host owns)
//   mem_we/mem_addr/mem_wdata        : memory request
//   mem_rdata                        : memory read data (asynchronous read)
// -----------------------------------------------------------------------------
module mem_port_mux #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              host_own,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_mem_write,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  assign mem_we     = host_own ? host_we    : cpu_mem_write;
  assign mem_addr   = host_own ? host_addr  : cpu_addr;
  assign mem_wdata  = host_own ? host_wdata : cpu_wdata;

  // The side without ownership sees zero so stale data never leaks across.
  assign host_rdata = host_own ? mem_rdata : '0;
  assign cpu_rdata  = host_own ? '0        : mem_rdata;

endmodule

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
// Sequences one run of the pipelined RSA core: host preloads memory, the core
// is released, end-PC is detected, the pipeline drains, memory returns to host.
//   clk, reset          : clock; synchronous active-low reset
//   host_go             : start a run (honoured in IDLE/DONE only)
//   host_we/addr/wdata  : host memory access; host_rdata read data
//   host_reject         : host_we seen while the core owned memory
//   end_pc              : PC marking program completion
//   cpu_rst, cpu_start  : core reset (active high) and start pulse
//   cpu_pc, cpu_mem_write, cpu_addr, cpu_wdata, cpu_rdata : core interface
//   mem_we/addr/wdata, mem_rdata : the single data-memory port
//   busy, done, timeout : run status (done/timeout sticky until next run)
//   cycle_count         : RUN+DRAIN cycles of the last/current run
// -----------------------------------------------------------------------------
module cpu_run_controller
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_go,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_reject,
  input  logic [DATA_W-1:0] end_pc,
  output logic              cpu_rst,
  output logic              cpu_start,
  input  logic [DATA_W-1:0] cpu_pc,
  input  logic              cpu_mem_write,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  // Wide enough to hold DRAIN_CYCLES-1.
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  if (DRAIN_CYCLES == 0) begin : g_bad_drain
    $error("cpu_run_controller: DRAIN_CYCLES must be at least 1");
  end

  run_state_t         state_q,   state_d;
  logic [DRAIN_W-1:0] drain_q,   drain_d;
  logic [CNT_W-1:0]   cycle_q,   cycle_d;
  logic               done_q,    done_d;
  logic               timeout_q, timeout_d;
  logic               start_q,   start_d;
  logic               reject_q,  reject_d;
  logic               busy_q,    busy_d;
  logic               cpu_rst_q, cpu_rst_d;

  logic [CNT_W-1:0]   cycle_inc;
  logic               end_hit;
  logic               wd_expired;

  assign cycle_inc  = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
  assign end_hit    = (cpu_pc == end_pc);
  assign wd_expired = (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    cycle_d   = cycle_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    start_d   = 1'b0;
    reject_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (host_go) begin
          state_d   = RUN;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cycle_d   = '0;
          start_d   = 1'b1;
        end
      end
      RUN: begin
        reject_d = host_we;
        cycle_d  = cycle_inc;
        // End-PC takes priority over a watchdog expiry in the same cycle.
        if (end_hit) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end else if (wd_expired) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        reject_d = host_we;
        cycle_d  = cycle_inc;
        if (drain_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d    = is_busy(state_d);
    cpu_rst_d = !busy_d;
  end

  // NOTE: reset is sampled on the clock edge (synchronous); asserting it
  // mid-run drops straight to IDLE without draining.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q   <= state_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign cpu_start   = start_q;
  assign cpu_rst     = cpu_rst_q;
  assign host_reject = reject_q;

  // Ownership follows the registered state, keeping the mux glitch-free.
  mem_port_mux #(
    .DATA_W (DATA_W)
  ) u_mem_port_mux (
    .host_own      (!is_busy(state_q)),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_controller
// Directed stimulus with a scoreboard: the stimulus process pushes expected
// responses into queues, a negedge monitor pops and compares them whenever the
// DUT presents the matching event (memory write, start pulse, reject pulse,
// end of run, host read, status snapshot).
// -----------------------------------------------------------------------------
module tb_cpu_run_controller;

  logic        clk;
  logic        reset;
  logic        host_go;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_reject;
  logic [31:0] end_pc;
  logic        cpu_rst;
  logic        cpu_start;
  logic [31:0] cpu_pc;
  logic        cpu_mem_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  cpu_run_controller #(
    .DATA_W         (32),
    .DRAIN_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_go       (host_go),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .host_reject   (host_reject),
    .end_pc        (end_pc),
    .cpu_rst       (cpu_rst),
    .cpu_start     (cpu_start),
    .cpu_pc        (cpu_pc),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .cycle_count   (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: PC held at 0 in reset, then advances by 4 per cycle.
  always @(posedge clk) begin
    if (cpu_rst) cpu_pc <= 32'h0;
    else         cpu_pc <= cpu_pc + 32'd4;
  end

  // Data memory: synchronous write, asynchronous read.
  logic [31:0] tbmem [0:255];
  always @(posedge clk) if (mem_we) tbmem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = tbmem[mem_addr[9:2]];

  // flags = {cpu_rst, cpu_start, busy, done, timeout, host_reject}
  typedef struct packed { logic [5:0] flags; logic [31:0] count; } status_t;
  // flags = {done, timeout, cpu_rst}
  typedef struct packed { int cyc; logic [2:0] flags; logic [31:0] count; } end_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  status_t     snap_q  [$];
  end_t        end_q   [$];
  wr_t         wr_q    [$];
  logic [31:0] rd_q    [$];
  int          start_q [$];
  int          rej_q   [$];

  logic snap_en = 1'b0;
  logic rd_en   = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic no_expect(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: unexpected event, value 0x%0h (cycle %0d)", name, act, cyc);
  endtask

  function automatic status_t mk_status(input logic rst, input logic st, input logic bsy,
                                        input logic dn, input logic to, input logic rj,
                                        input logic [31:0] cnt);
    mk_status.flags = {rst, st, bsy, dn, to, rj};
    mk_status.count = cnt;
  endfunction

  function automatic end_t mk_end(input int c, input logic dn, input logic to,
                                  input logic rst, input logic [31:0] cnt);
    mk_end.cyc   = c;
    mk_end.flags = {dn, to, rst};
    mk_end.count = cnt;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic    prev_busy = 1'b0;
  status_t m_s;
  end_t    m_e;
  wr_t     m_w;
  int      m_c;

  always @(negedge clk) begin
    if (snap_en) begin
      if (snap_q.size() == 0) no_expect("status_snap", {26'd0, cpu_rst, cpu_start, busy, done, timeout, host_reject, cycle_count});
      else begin
        m_s = snap_q.pop_front();
        check("status_flags", {58'd0, cpu_rst, cpu_start, busy, done, timeout, host_reject}, {58'd0, m_s.flags});
        check("status_count", {32'd0, cycle_count}, {32'd0, m_s.count});
      end
    end
    if (rd_en) begin
      if (rd_q.size() == 0) no_expect("host_read", {32'd0, host_rdata});
      else check("host_rdata", {32'd0, host_rdata}, {32'd0, rd_q.pop_front()});
    end
    if (mem_we) begin
      if (wr_q.size() == 0) no_expect("stray_mem_write", {mem_addr, mem_wdata});
      else begin
        m_w = wr_q.pop_front();
        check("mem_addr",  {32'd0, mem_addr},  {32'd0, m_w.addr});
        check("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_w.data});
      end
    end
    if (cpu_start) begin
      if (start_q.size() == 0) no_expect("cpu_start_pulse", 64'(cyc));
      else begin
        m_c = start_q.pop_front();
        check("cpu_start_cycle", 64'(cyc), 64'(m_c));
      end
    end
    if (host_reject) begin
      if (rej_q.size() == 0) no_expect("host_reject_pulse", 64'(cyc));
      else begin
        m_c = rej_q.pop_front();
        check("host_reject_cycle", 64'(cyc), 64'(m_c));
      end
    end
    if (prev_busy && !busy) begin
      if (end_q.size() == 0) no_expect("run_end", 64'(cyc));
      else begin
        m_e = end_q.pop_front();
        check("end_cycle", 64'(cyc), 64'(m_e.cyc));
        check("end_flags", {61'd0, done, timeout, cpu_rst}, {61'd0, m_e.flags});
        check("end_count", {32'd0, cycle_count}, {32'd0, m_e.count});
      end
    end
    prev_busy = busy;
  end

  // -------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input status_t s);
    snap_q.push_back(s);
    snap_en = 1'b1;
    step();
    snap_en = 1'b0;
  endtask

  task automatic host_read(input logic [31:0] a, input logic [31:0] e);
    host_addr = a;
    rd_q.push_back(e);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic go(input logic [31:0] pc_end, output int c);
    end_pc  = pc_end;
    host_go = 1'b1;
    c       = cyc;
    start_q.push_back(c + 1);
    step();
    host_go = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      step();
      k++;
    end
    check("run_terminates", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    reset         = 1'b0;
    host_go       = 1'b0;
    host_we       = 1'b0;
    host_addr     = '0;
    host_wdata    = '0;
    end_pc        = '0;
    cpu_mem_write = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;

    // Reset held for three edges, then released: reset values everywhere.
    repeat (3) step();
    reset = 1'b1;
    snap(mk_status(1, 0, 0, 0, 0, 0, 0));

    // Host preload and readback while the host owns memory.
    host_we    = 1'b1;
    host_addr  = 32'h10;
    host_wdata = 32'hDEAD_BEEF;
    wr_q.push_back({32'h10, 32'hDEAD_BEEF});
    step();
    host_we = 1'b0;
    host_read(32'h10, 32'hDEAD_BEEF);

    // Run 1: end_pc 0x20 -> 9 RUN + 4 DRAIN cycles. Core writes in the first
    // RUN cycle while the host also tries to write (must be rejected).
    go(32'h20, c);
    end_q.push_back(mk_end(c + 14, 1, 0, 1, 13));
    cpu_mem_write = 1'b1;
    cpu_addr      = 32'h40;
    cpu_wdata     = 32'h1234;
    host_we       = 1'b1;
    host_addr     = 32'h44;
    host_wdata    = 32'hBAD0_BAD0;
    wr_q.push_back({32'h40, 32'h1234});
    rej_q.push_back(c + 2);
    step();
    cpu_mem_write = 1'b0;
    host_we       = 1'b0;
    snap(mk_status(0, 0, 1, 0, 0, 1, 1));
    wait_idle();
    snap(mk_status(1, 0, 0, 1, 0, 0, 13));
    host_read(32'h40, 32'h1234);

    // Run 2: end_pc unreachable -> watchdog after 16 RUN cycles. Started from
    // DONE, so done must clear and the count restart.
    go(32'hFFFF_0000, c);
    end_q.push_back(mk_end(c + 17, 0, 1, 1, 16));
    snap(mk_status(0, 1, 1, 0, 0, 0, 0));
    wait_idle();
    snap(mk_status(1, 0, 0, 0, 1, 0, 16));

    // Run 3: restart from a timed-out DONE, completes normally.
    go(32'h20, c);
    end_q.push_back(mk_end(c + 14, 1, 0, 1, 13));
    snap(mk_status(0, 1, 1, 0, 0, 0, 0));
    wait_idle();
    snap(mk_status(1, 0, 0, 1, 0, 0, 13));

    // Run 4: end_pc 0x08 -> DRAIN from c+4; reset in the second DRAIN cycle.
    // The core keeps requesting writes; only the one still in DRAIN may pass.
    go(32'h08, c);
    end_q.push_back(mk_end(c + 6, 0, 0, 1, 0));
    repeat (4) step();
    reset         = 1'b0;
    cpu_mem_write = 1'b1;
    cpu_addr      = 32'h80;
    cpu_wdata     = 32'h55;
    wr_q.push_back({32'h80, 32'h55});
    step();
    reset = 1'b1;
    snap(mk_status(1, 0, 0, 0, 0, 0, 0));
    repeat (3) step();
    cpu_mem_write = 1'b0;
    host_read(32'h80, 32'h55);

    repeat (2) step();
    check("snap_q_empty",  64'(snap_q.size()),  64'd0);
    check("end_q_empty",   64'(end_q.size()),   64'd0);
    check("wr_q_empty",    64'(wr_q.size()),    64'd0);
    check("rd_q_empty",    64'(rd_q.size()),    64'd0);
    check("start_q_empty", 64'(start_q.size()), 64'd0);
    check("rej_q_empty",   64'(rej_q.size()),   64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences one run of the pipelined RSA processor: the host preloads data memory, the block releases the core, detects completion, drains the pipeline and hands memory back to the host.
- Owns the single data-memory port and muxes it between the host interface and the core's M-stage (MemWrite/ALUResult/WriteData).
- Sits between the top level and pipelined_processor; it drives the core's reset and start inputs.

Parameters:
- DATA_W, 32, data and address width.
- DRAIN_CYCLES, 4, cycles held after end-PC detection so in-flight instructions reach writeback.
- TIMEOUT_CYCLES, 1000000, maximum RUN-state cycles before forced stop.
- CNT_W, 32, width of cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low: controller resets when reset==0 at a clk edge.
- host_go  in  1  request a run; sampled in IDLE/DONE only.
- host_we  in  1  host memory write strobe.
- host_addr  in  DATA_W  host memory address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  memory read data to host; 0 when host lacks ownership.
- host_reject  out  1  one-cycle pulse: host_we arrived while core owns memory.
- end_pc  in  DATA_W  PC value that marks program completion.
- cpu_rst  out  1  active-high reset to core.
- cpu_start  out  1  start to core.
- cpu_pc  in  DATA_W  core PC.
- cpu_mem_write  in  1  core MemWrite.
- cpu_addr  in  DATA_W  core ALUResult (M stage).
- cpu_wdata  in  DATA_W  core WriteData.
- cpu_rdata  out  DATA_W  memory read data to core.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (asynchronous read).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  sticky, set on normal completion.
- timeout  out  1  sticky, set on watchdog stop.
- cycle_count  out  CNT_W  cycles spent in RUN+DRAIN of the last/current run.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Reset (reset==0) goes to IDLE and sets every output to its reset value: cpu_rst=1, cpu_start=0, busy=0, done=0, timeout=0, cycle_count=0, host_reject=0, drain counter=0. Reset mid-run aborts immediately, with no drain.
- IDLE/DONE: host owns memory.
  - mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata, host_rdata=mem_rdata, cpu_rdata=0; cpu_rst=1.
  - host_go=1 moves to RUN on the next edge and clears done, timeout and cycle_count.
  - A host_we in the same cycle as host_go is still performed.
- RUN:
  - The core owns memory: mem_we=cpu_mem_write, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_rdata=mem_rdata, host_rdata=0.
  - host_we is ignored, and host_reject=1 is registered for the following cycle.
  - cpu_rst=0. cpu_start=1 for exactly the first RUN cycle, then 0.
  - cycle_count increments each cycle and saturates at all-ones.
  - cpu_pc==end_pc moves to DRAIN and loads the drain counter with DRAIN_CYCLES-1.
  - When cycle_count==TIMEOUT_CYCLES-1 and end_pc has not been hit, go to DONE with timeout=1 and done=0. If both occur in the same cycle, end_pc wins.
- DRAIN:
  - Core still owns memory and is still out of reset; cycle_count keeps counting.
  - The drain counter decrements; at 0, go to DONE with done=1.
  - DRAIN_CYCLES=0 is illegal (elaboration assert).
- DONE: same as IDLE but done/timeout are held. host_go starts a new run.
- host_go while busy is ignored.
- Latency: host_go to cpu_rst deassert is 1 cycle. end_pc hit to done is DRAIN_CYCLES cycles.
- The memory mux is combinational from registered state. All other outputs are registered.

Decomposition:
- Package rsa_ctrl_pkg holds:
  - typedef enum logic [1:0] run_state_t {IDLE, RUN, DRAIN, DONE};
  - default DRAIN_CYCLES and TIMEOUT_CYCLES constants.
- One sub-module, mem_port_mux (combinational owner-select for we/addr/wdata/rdata), keeps the FSM file small.

Test Plan:
- Reset held 0 for 3 cycles, then released → cpu_rst=1, busy=0, done=0, cycle_count=0, host write to addr 0x10 with 0xDEADBEEF reaches mem, and host_rdata reads it back.
- host_go with end_pc=0x20, core PC advancing by 4 per cycle from 0 → cpu_start high for 1 cycle, PC hits 0x20 after 9 RUN cycles, then 4 DRAIN cycles, then done=1, busy=0, cycle_count=13.
- In RUN, core drives MemWrite=1, addr 0x40, data 0x1234 → mem sees it. A simultaneous host_we → not written, host_reject pulses once.
- TIMEOUT_CYCLES=16, end_pc never reached → DONE after 16 cycles, timeout=1, done=0, cpu_rst=1.
- Reset driven 0 during DRAIN → next cycle IDLE, cpu_rst=1, done=0, and no further core memory writes pass.
- host_go in DONE → done and timeout clear, cycle_count restarts at 0, and a second run completes normally.
